// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states, requester IDs and the
// full-word byte-enable constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ISIDE = 1'b0,
    DSIDE = 1'b1
  } side_e;

  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

endpackage

// File: rtl/arb_pick2.sv
// Two-way round-robin pick between the instruction and data requesters.
// On a tie the side opposite to the previous winner is chosen.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic  ireq_i,
  input  logic  dreq_i,
  input  side_e last_i,
  output logic  valid_o,
  output side_e pick_o
);

  always_comb begin
    valid_o = ireq_i | dreq_i;
    pick_o  = ISIDE;
    if (ireq_i && dreq_i) begin
      pick_o = (last_i == ISIDE) ? DSIDE : ISIDE;
    end else if (dreq_i) begin
      pick_o = DSIDE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the mips I-fetch and D sides: one transaction at a
// time, single-cycle ack to the winner, watchdog forces completion of a stalled access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          ph1,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iadr,
  output logic [DW-1:0] irdata,
  output logic          iack,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] dadr,
  input  logic [DW-1:0] dwdata,
  input  logic [3:0]    dbyteen,
  output logic [DW-1:0] drdata,
  output logic          dack,
  output logic          err,
  output logic          memreq,
  output logic          memwe,
  output logic [AW-1:0] memadr,
  output logic [DW-1:0] memwdata,
  output logic [3:0]    membyteen,
  input  logic [DW-1:0] memrdata,
  input  logic          memack
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e    state_q, state_d;
  side_e         last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          memreq_q, memreq_d;
  logic          memwe_q, memwe_d;
  logic [AW-1:0] memadr_q, memadr_d;
  logic [DW-1:0] memwdata_q, memwdata_d;
  logic [3:0]    membyteen_q, membyteen_d;
  logic [DW-1:0] irdata_q, irdata_d;
  logic [DW-1:0] drdata_q, drdata_d;
  logic          iack_q, iack_d;
  logic          dack_q, dack_d;
  logic          err_q, err_d;

  logic  grant_valid;
  side_e grant_side;

  arb_pick2 u_pick (
    .ireq_i  (ireq),
    .dreq_i  (dreq),
    .last_i  (last_q),
    .valid_o (grant_valid),
    .pick_o  (grant_side)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    timer_d     = timer_q;
    memreq_d    = memreq_q;
    memwe_d     = memwe_q;
    memadr_d    = memadr_q;
    memwdata_d  = memwdata_q;
    membyteen_d = membyteen_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (grant_valid) begin
          state_d  = BUSY;
          memreq_d = 1'b1;
          last_d   = grant_side;
          if (grant_side == DSIDE) begin
            memwe_d     = dwe;
            memadr_d    = dadr;
            memwdata_d  = dwdata;
            membyteen_d = dwe ? dbyteen : BYTEEN_ALL;
          end else begin
            memwe_d     = 1'b0;
            memadr_d    = iadr;
            memwdata_d  = '0;
            membyteen_d = BYTEEN_ALL;
          end
        end
      end

      BUSY: begin
        if (timer_q != {TW{1'b1}}) timer_d = timer_q + 1'b1;
        // last_q holds the current winner for the whole transaction
        if (memack) begin
          state_d  = RESP;
          memreq_d = 1'b0;
          if (last_q == ISIDE) begin
            irdata_d = memrdata;
            iack_d   = 1'b1;
          end else begin
            drdata_d = memwe_q ? '0 : memrdata;
            dack_d   = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (timer_q == TLAST)) begin
          state_d  = RESP;
          memreq_d = 1'b0;
          err_d    = 1'b1;
          if (last_q == ISIDE) begin
            irdata_d = '0;
            iack_d   = 1'b1;
          end else begin
            drdata_d = '0;
            dack_d   = 1'b1;
          end
        end
      end

      RESP: begin
        timer_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= ISIDE;
      timer_q     <= '0;
      memreq_q    <= 1'b0;
      memwe_q     <= 1'b0;
      memadr_q    <= '0;
      memwdata_q  <= '0;
      membyteen_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      memreq_q    <= memreq_d;
      memwe_q     <= memwe_d;
      memadr_q    <= memadr_d;
      memwdata_q  <= memwdata_d;
      membyteen_q <= membyteen_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      err_q       <= err_d;
    end
  end

  assign memreq    = memreq_q;
  assign memwe     = memwe_q;
  assign memadr    = memadr_q;
  assign memwdata  = memwdata_q;
  assign membyteen = membyteen_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign iack      = iack_q;
  assign dack      = dack_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector tables for the write and tie cases,
// hand-written sequences for reset, watchdog and memack/timeout collisions.
module tb_mem_arbiter;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        ireq, dreq, dwe, memack;
  logic [31:0] iadr, dadr, dwdata, memrdata;
  logic [3:0]  dbyteen;
  logic [31:0] irdata, drdata, memadr, memwdata;
  logic        iack, dack, err, memreq, memwe;
  logic [3:0]  membyteen;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ph1 = ~ph1;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .ph1(ph1), .reset(reset),
    .ireq(ireq), .iadr(iadr), .irdata(irdata), .iack(iack),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata), .dbyteen(dbyteen),
    .drdata(drdata), .dack(dack), .err(err),
    .memreq(memreq), .memwe(memwe), .memadr(memadr), .memwdata(memwdata),
    .membyteen(membyteen), .memrdata(memrdata), .memack(memack)
  );

  typedef struct {
    logic        ireq;
    logic [31:0] iadr;
    logic        dreq;
    logic        dwe;
    logic [31:0] dadr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        memack;
    logic [31:0] memrdata;
    logic        x_req;
    logic        chk_mem;
    logic        x_we;
    logic [31:0] x_adr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic        x_iack;
    logic        x_dack;
    logic        x_err;
    logic [31:0] x_ir;
    logic [31:0] x_dr;
  } vec_t;

  vec_t tie_tbl[$];
  vec_t wr_tbl[$];

  function automatic vec_t v(
    input logic ir, input logic [31:0] ia, input logic dr, input logic we,
    input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
    input logic ma, input logic [31:0] mr,
    input logic xreq, input logic chk, input logic xwe, input logic [31:0] xadr,
    input logic [3:0] xbe, input logic [31:0] xwd,
    input logic xia, input logic xda, input logic xer,
    input logic [31:0] xir, input logic [31:0] xdr);
    vec_t r;
    r.ireq = ir; r.iadr = ia; r.dreq = dr; r.dwe = we; r.dadr = da; r.dwdata = wd;
    r.dbe = be; r.memack = ma; r.memrdata = mr;
    r.x_req = xreq; r.chk_mem = chk; r.x_we = xwe; r.x_adr = xadr; r.x_be = xbe;
    r.x_wdata = xwd; r.x_iack = xia; r.x_dack = xda; r.x_err = xer;
    r.x_ir = xir; r.x_dr = xdr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic idle_inputs();
    ireq = 0; iadr = '0; dreq = 0; dwe = 0; dadr = '0; dwdata = '0; dbyteen = '0;
    memack = 0; memrdata = '0;
  endtask

  task automatic run_vec(input string tag, input vec_t r);
    ireq = r.ireq; iadr = r.iadr; dreq = r.dreq; dwe = r.dwe; dadr = r.dadr;
    dwdata = r.dwdata; dbyteen = r.dbe; memack = r.memack; memrdata = r.memrdata;
    tick();
    chk({tag, ".memreq"}, {31'b0, memreq}, {31'b0, r.x_req});
    chk({tag, ".iack"}, {31'b0, iack}, {31'b0, r.x_iack});
    chk({tag, ".dack"}, {31'b0, dack}, {31'b0, r.x_dack});
    chk({tag, ".err"}, {31'b0, err}, {31'b0, r.x_err});
    chk({tag, ".irdata"}, irdata, r.x_ir);
    chk({tag, ".drdata"}, drdata, r.x_dr);
    if (r.chk_mem) begin
      chk({tag, ".memwe"}, {31'b0, memwe}, {31'b0, r.x_we});
      chk({tag, ".memadr"}, memadr, r.x_adr);
      chk({tag, ".membyteen"}, {28'b0, membyteen}, {28'b0, r.x_be});
      chk({tag, ".memwdata"}, memwdata, r.x_wdata);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".memreq"}, {31'b0, memreq}, 32'd0);
    chk({tag, ".memwe"}, {31'b0, memwe}, 32'd0);
    chk({tag, ".memadr"}, memadr, 32'd0);
    chk({tag, ".memwdata"}, memwdata, 32'd0);
    chk({tag, ".membyteen"}, {28'b0, membyteen}, 32'd0);
    chk({tag, ".iack"}, {31'b0, iack}, 32'd0);
    chk({tag, ".dack"}, {31'b0, dack}, 32'd0);
    chk({tag, ".err"}, {31'b0, err}, 32'd0);
    chk({tag, ".irdata"}, irdata, 32'd0);
    chk({tag, ".drdata"}, drdata, 32'd0);
  endtask

  localparam logic [31:0] IW  = 32'h8C22_0004;
  localparam logic [31:0] D1  = 32'h1111_2222;
  localparam logic [31:0] D2  = 32'h3333_4444;
  localparam logic [31:0] CAF = 32'hCAFE_F00D;

  initial begin
    // Both sides requesting continuously with memack held high: D, I, D, I.
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,D1, 1,1,0,32'h200,4'hF,0, 0,0,0,0,0));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,D1, 0,0,0,0,0,0, 0,1,0,0,D1));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,IW, 0,0,0,0,0,0, 0,0,0,0,D1));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,IW, 1,1,0,32'h100,4'hF,0, 0,0,0,0,D1));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,IW, 0,0,0,0,0,0, 1,0,0,IW,D1));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,D2, 0,0,0,0,0,0, 0,0,0,IW,D1));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,D2, 1,1,0,32'h200,4'hF,0, 0,0,0,IW,D1));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,D2, 0,0,0,0,0,0, 0,1,0,IW,D2));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,IW, 0,0,0,0,0,0, 0,0,0,IW,D2));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,IW, 1,1,0,32'h100,4'hF,0, 0,0,0,IW,D2));
    tie_tbl.push_back(v(1,32'h100,1,0,32'h200,0,4'h3,1,IW, 0,0,0,0,0,0, 1,0,0,IW,D2));
    tie_tbl.push_back(v(0,32'h0,0,0,32'h0,0,4'h0,0,0, 0,0,0,0,0,0, 0,0,0,IW,D2));

    // D write with memack on the third BUSY cycle; writes return zero read data.
    wr_tbl.push_back(v(0,0,1,1,32'h40,CAF,4'h3,0,0, 1,1,1,32'h40,4'h3,CAF, 0,0,0,IW,D2));
    wr_tbl.push_back(v(0,0,1,1,32'h40,CAF,4'h3,0,0, 1,1,1,32'h40,4'h3,CAF, 0,0,0,IW,D2));
    wr_tbl.push_back(v(0,0,1,1,32'h40,CAF,4'h3,0,0, 1,1,1,32'h40,4'h3,CAF, 0,0,0,IW,D2));
    wr_tbl.push_back(v(0,0,1,1,32'h40,CAF,4'h3,1,32'hFFFF_FFFF, 0,0,0,0,0,0, 0,1,0,IW,0));
    wr_tbl.push_back(v(0,0,0,0,32'h0,0,4'h0,0,0, 0,0,0,0,0,0, 0,0,0,IW,0));
  end

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Reset held with random inputs: every output stays zero.
    for (int i = 0; i < 4; i++) begin
      ireq = 1'($urandom); dreq = 1'($urandom); dwe = 1'($urandom); memack = 1'($urandom);
      iadr = $urandom; dadr = $urandom; dwdata = $urandom; memrdata = $urandom;
      dbyteen = 4'($urandom);
      tick();
      chk_all_zero("reset");
    end
    idle_inputs();
    @(negedge ph1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle.memreq", {31'b0, memreq}, 32'd0);
      chk("idle.acks", {30'b0, iack, dack}, 32'd0);
    end

    // Fresh reset so the first tie goes to D.
    reset = 1'b0;
    #2;
    @(negedge ph1);
    reset = 1'b1;
    foreach (tie_tbl[i]) run_vec($sformatf("tie[%0d]", i), tie_tbl[i]);
    foreach (wr_tbl[i]) run_vec($sformatf("dwr[%0d]", i), wr_tbl[i]);

    // Watchdog: I read never acknowledged.
    idle_inputs();
    ireq = 1; iadr = 32'h300;
    tick();
    chk("to.grant.memreq", {31'b0, memreq}, 32'd1);
    chk("to.grant.memadr", memadr, 32'h300);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to.busy.memreq", {31'b0, memreq}, 32'd1);
      chk("to.busy.iack", {31'b0, iack}, 32'd0);
    end
    tick();
    chk("to.resp.memreq", {31'b0, memreq}, 32'd0);
    chk("to.resp.iack", {31'b0, iack}, 32'd1);
    chk("to.resp.err", {31'b0, err}, 32'd1);
    chk("to.resp.irdata", irdata, 32'd0);
    ireq = 0;
    tick();
    chk("to.idle.ackerr", {30'b0, iack, err}, 32'd0);
    memack = 1; memrdata = 32'hDEAD_BEEF;
    tick();
    chk("late.memreq", {31'b0, memreq}, 32'd0);
    chk("late.acks", {30'b0, iack, dack}, 32'd0);
    chk("late.irdata", irdata, 32'd0);
    memack = 0;
    tick();

    // memack on the same cycle the watchdog would fire: normal completion.
    dreq = 1; dwe = 0; dadr = 32'h44; dbyteen = 4'h1; memrdata = 32'h5A5A_1234;
    tick();
    chk("both.grant.memreq", {31'b0, memreq}, 32'd1);
    chk("both.grant.be", {28'b0, membyteen}, 32'hF);
    for (int i = 0; i < 3; i++) tick();
    chk("both.busy.memreq", {31'b0, memreq}, 32'd1);
    memack = 1;
    tick();
    chk("both.resp.dack", {31'b0, dack}, 32'd1);
    chk("both.resp.err", {31'b0, err}, 32'd0);
    chk("both.resp.drdata", drdata, 32'h5A5A_1234);
    dreq = 0; memack = 0;
    tick();
    chk("both.idle.dack", {31'b0, dack}, 32'd0);

    // Reset in the middle of a write: abandoned, then the still-pending dreq restarts.
    dreq = 1; dwe = 1; dadr = 32'h80; dwdata = 32'h1234_5678; dbyteen = 4'hC;
    tick();
    tick();
    chk("rst.busy.memreq", {31'b0, memreq}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst.async.memreq", {31'b0, memreq}, 32'd0);
    chk("rst.async.memadr", memadr, 32'd0);
    tick();
    chk("rst.hold.acks", {30'b0, iack, dack}, 32'd0);
    @(negedge ph1);
    reset = 1'b1;
    tick();
    chk("rst.regrant.memreq", {31'b0, memreq}, 32'd1);
    chk("rst.regrant.memadr", memadr, 32'h80);
    chk("rst.regrant.be", {28'b0, membyteen}, 32'hC);
    chk("rst.regrant.memwe", {31'b0, memwe}, 32'd1);
    chk("rst.regrant.dack", {31'b0, dack}, 32'd0);
    memack = 1;
    tick();
    chk("rst.done.dack", {31'b0, dack}, 32'd1);
    chk("rst.done.err", {31'b0, err}, 32'd0);
    dreq = 0; memack = 0;
    tick();
    chk("rst.done.idle", {30'b0, dack, memreq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
